// File: rtl/adder_pkg.sv
// Shared constants and configuration helpers for the segmented add/subtract pipeline.
package adder_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int unsigned calc_nseg(input int unsigned width, input int unsigned seg_w);
      return (seg_w == 0) ? 0 : width / seg_w;
   endfunction

   function automatic bit seg_cfg_ok(input int unsigned width, input int unsigned seg_w);
      return (seg_w != 0) && (width >= seg_w) && ((width % seg_w) == 0);
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seg_adder.sv
// Combinational W-bit ripple adder built from full_adder cells; exposes the MSB carry-in for overflow.
module seg_adder #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co,
   output logic         c_msb
);

   logic [W:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < W; i++) begin : g_bit
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign co    = c[W];
   assign c_msb = c[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract unit, one SEG_W-bit segment resolved per pipeline stage,
// with valid/ready handshakes and a single global advance enable.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SEG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NSEG = calc_nseg(WIDTH, SEG_W);

   if (!seg_cfg_ok(WIDTH, SEG_W)) begin : g_cfg_err
      $error("pipelined_adder: WIDTH must be a non-zero multiple of SEG_W");
   end

   logic             adv;
   logic [WIDTH-1:0] b_x;
   logic             cin_x;

   // Stage k inputs: primary operands for k=0, previous stage registers otherwise.
   logic [NSEG-1:0]  v_in;
   logic [NSEG-1:0]  c_in;
   logic [WIDTH-1:0] a_in [NSEG];
   logic [WIDTH-1:0] b_in [NSEG];
   logic [WIDTH-1:0] s_in [NSEG];
   logic [WIDTH-1:0] s_d  [NSEG];

   logic [SEG_W-1:0] seg_s  [NSEG];
   logic [NSEG-1:0]  seg_co;
   logic             seg_cm [NSEG];

   logic [NSEG-1:0]  v_q;
   logic [NSEG-1:0]  c_q;
   logic [WIDTH-1:0] a_q [NSEG];
   logic [WIDTH-1:0] b_q [NSEG];
   logic [WIDTH-1:0] s_q [NSEG];
   logic             ovf_q;

   assign adv      = !v_q[NSEG-1] || out_ready;
   assign in_ready = adv;

   assign b_x   = (sub == MODE_SUB) ? ~b : b;
   assign cin_x = (sub == MODE_SUB) ? 1'b1 : cin;

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign v_in[k] = in_valid;
         assign c_in[k] = cin_x;
         assign a_in[k] = a;
         assign b_in[k] = b_x;
         assign s_in[k] = '0;
      end else begin : g_next
         assign v_in[k] = v_q[k-1];
         assign c_in[k] = c_q[k-1];
         assign a_in[k] = a_q[k-1];
         assign b_in[k] = b_q[k-1];
         assign s_in[k] = s_q[k-1];
      end

      seg_adder #(.W(SEG_W)) u_seg (
         .a     (a_in[k][k*SEG_W +: SEG_W]),
         .b     (b_in[k][k*SEG_W +: SEG_W]),
         .ci    (c_in[k]),
         .s     (seg_s[k]),
         .co    (seg_co[k]),
         .c_msb (seg_cm[k])
      );
   end

   always_comb begin
      for (int unsigned k = 0; k < NSEG; k++) begin
         s_d[k] = s_in[k];
         s_d[k][k*SEG_W +: SEG_W] = seg_s[k];
      end
   end

   // Signed overflow as carry-into-MSB xor carry-out: same as the operand-sign form.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q   <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int unsigned k = 0; k < NSEG; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else if (adv) begin
         v_q   <= v_in;
         c_q   <= seg_co;
         ovf_q <= seg_co[NSEG-1] ^ seg_cm[NSEG-1];
         for (int unsigned k = 0; k < NSEG; k++) begin
            a_q[k] <= a_in[k];
            b_q[k] <= b_in[k];
            s_q[k] <= s_d[k];
         end
      end
   end

   assign out_valid = v_q[NSEG-1];
   assign sum       = s_q[NSEG-1];
   assign cout      = c_q[NSEG-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder with WIDTH=8, SEG_W=4 (latency 2).
module tb_pipelined_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       cin = 1'b0;
   logic       sub = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] sum;
   logic       cout;
   logic       ovf;

   int checks = 0;
   int errors = 0;

   pipelined_adder #(.WIDTH(8), .SEG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Presents one beat, returns out_valid one and two cycles later plus the result.
   task automatic drive_one(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic sb,
                            output logic v1, output logic v2, output logic [7:0] s,
                            output logic co, output logic ov);
      @(negedge clk);
      in_valid = 1'b1; a = av; b = bv; cin = ci; sub = sb;
      @(negedge clk);
      v1 = out_valid;
      in_valid = 1'b0;
      @(negedge clk);
      v2 = out_valid; s = sum; co = cout; ov = ovf;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      checks++; if (sum !== 8'h00) begin errors++; $display("FAIL rst_sum got %h want 00", sum); end
      checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b want 00", {cout, ovf}); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_add();
      logic v1, v2, co, ov;
      logic [7:0] s;
      drive_one(8'h0F, 8'h01, 1'b0, 1'b0, v1, v2, s, co, ov);
      checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b want 0", v1); end
      checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL add_latency_valid got %b want 1", v2); end
      checks++; if (s !== 8'h10) begin errors++; $display("FAIL add_sum got %h want 10", s); end
      checks++; if ({co, ov} !== 2'b00) begin errors++; $display("FAIL add_flags got %b want 00", {co, ov}); end
      drive_one(8'h0F, 8'h00, 1'b1, 1'b0, v1, v2, s, co, ov);
      checks++; if (v2 !== 1'b1 || s !== 8'h10) begin errors++; $display("FAIL add_cin got v=%b s=%h want v=1 s=10", v2, s); end
   endtask

   task automatic test_carry_chain();
      logic v1, v2, co, ov;
      logic [7:0] s;
      drive_one(8'hFF, 8'h01, 1'b0, 1'b0, v1, v2, s, co, ov);
      checks++; if (v2 !== 1'b1 || s !== 8'h00) begin errors++; $display("FAIL chain_ff_sum got v=%b s=%h want v=1 s=00", v2, s); end
      checks++; if ({co, ov} !== 2'b10) begin errors++; $display("FAIL chain_ff_flags got %b want 10", {co, ov}); end
      drive_one(8'h7F, 8'h01, 1'b0, 1'b0, v1, v2, s, co, ov);
      checks++; if (v2 !== 1'b1 || s !== 8'h80) begin errors++; $display("FAIL chain_7f_sum got v=%b s=%h want v=1 s=80", v2, s); end
      checks++; if ({co, ov} !== 2'b01) begin errors++; $display("FAIL chain_7f_flags got %b want 01", {co, ov}); end
   endtask

   task automatic test_subtract();
      logic v1, v2, co, ov;
      logic [7:0] s;
      drive_one(8'h05, 8'h07, 1'b1, 1'b1, v1, v2, s, co, ov);
      checks++; if (v2 !== 1'b1 || s !== 8'hFE) begin errors++; $display("FAIL sub_borrow_sum got v=%b s=%h want v=1 s=fe", v2, s); end
      checks++; if ({co, ov} !== 2'b00) begin errors++; $display("FAIL sub_borrow_flags got %b want 00", {co, ov}); end
      drive_one(8'h80, 8'h01, 1'b1, 1'b1, v1, v2, s, co, ov);
      checks++; if (v2 !== 1'b1 || s !== 8'h7F) begin errors++; $display("FAIL sub_ovf_sum got v=%b s=%h want v=1 s=7f", v2, s); end
      checks++; if ({co, ov} !== 2'b11) begin errors++; $display("FAIL sub_ovf_flags got %b want 11", {co, ov}); end
      sub = 1'b0; cin = 1'b0;
   endtask

   task automatic test_back_pressure();
      logic [7:0] ina   [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
      logic [7:0] inb   [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      logic [7:0] exp_s [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      int tx = 0;
      int rx = 0;
      int stall = 0;
      bit seen = 1'b0;
      for (int cyc = 0; cyc < 30 && rx < 4; cyc++) begin
         @(negedge clk);
         if (out_valid && !seen) begin seen = 1'b1; stall = 3; end
         out_ready = (stall == 0);
         if (stall > 0) stall--;
         in_valid = (tx < 4);
         if (tx < 4) begin a = ina[tx]; b = inb[tx]; end
         cin = 1'b0; sub = 1'b0;
         #1;
         if (!out_ready) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
            checks++; if (out_valid !== 1'b1 || sum !== exp_s[rx]) begin errors++; $display("FAIL bp_hold got v=%b s=%h want v=1 s=%h", out_valid, sum, exp_s[rx]); end
         end else if (out_valid) begin
            checks++; if (sum !== exp_s[rx]) begin errors++; $display("FAIL bp_order beat %0d got %h want %h", rx, sum, exp_s[rx]); end
            rx++;
         end
         if (in_valid && in_ready) tx++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (rx != 4) begin errors++; $display("FAIL bp_count got %0d want 4", rx); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate got out_valid=%b want 0", out_valid); end
      end
   endtask

   task automatic test_bubbles();
      logic       vin  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [7:0] ina  [6] = '{8'h12, 8'hFF, 8'hA0, 8'h00, 8'h00, 8'h00};
      logic [7:0] inb  [6] = '{8'h34, 8'hFF, 8'h0B, 8'h00, 8'h00, 8'h00};
      logic       ev   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [7:0] es   [6] = '{8'h00, 8'h00, 8'h46, 8'h00, 8'hAB, 8'h00};
      out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++; if (out_valid !== ev[c]) begin errors++; $display("FAIL bubble_valid cyc %0d got %b want %b", c, out_valid, ev[c]); end
         if (ev[c]) begin
            checks++; if (sum !== es[c]) begin errors++; $display("FAIL bubble_sum cyc %0d got %h want %h", c, sum, es[c]); end
         end
         in_valid = vin[c]; a = ina[c]; b = inb[c];
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic v1, v2, co, ov;
      logic [7:0] s;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; a = 8'h11; b = 8'h22;
      @(negedge clk);
      a = 8'h33; b = 8'h44;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || sum !== 8'h33) begin errors++; $display("FAIL rmid_pre got v=%b s=%h want v=1 s=33", out_valid, sum); end
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", out_valid); end
      checks++; if (sum !== 8'h00 || {cout, ovf} !== 2'b00) begin errors++; $display("FAIL rmid_clear got s=%h f=%b want s=00 f=00", sum, {cout, ovf}); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale got out_valid=%b want 0", out_valid); end
      end
      drive_one(8'h01, 8'h01, 1'b0, 1'b0, v1, v2, s, co, ov);
      checks++; if (v1 !== 1'b0 || v2 !== 1'b1) begin errors++; $display("FAIL rmid_latency got %b%b want 01", v1, v2); end
      checks++; if (s !== 8'h02) begin errors++; $display("FAIL rmid_sum got %h want 02", s); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_carry_chain();
      test_subtract();
      test_back_pressure();
      test_bubbles();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
